// File: rtl/multiword_add_seq.sv
// Wide adder that walks one 8-bit add-with-carry across WORDS byte limbs, LSB first,
// with valid/ready handshakes on the operand and result sides.
module multiword_add_seq #(
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*WORDS-1:0]   a,
  input  logic [8*WORDS-1:0]   b,
  input  logic                 carry_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*WORDS-1:0]   sum,
  output logic                 carry_out,
  output logic                 busy
);

  localparam int W     = 8 * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_next;
  logic [IDX_W-1:0]  idx;
  logic [W-1:0]      a_reg, b_reg, result_reg, result_next;
  logic              carry_reg;
  logic [7:0]        a_limb, b_limb;
  logic [8:0]        limb_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)        state_next = RUN;
      RUN:     if (idx == LAST_IDX) state_next = DONE;
      DONE:    if (out_ready)       state_next = IDLE;
      default:                      state_next = IDLE;
    endcase
  end

  // Shared 8-bit adder: select the current limb, add with the chained carry,
  // and merge the byte back into its slot of the result.
  always_comb begin
    a_limb = '0;
    b_limb = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (idx == IDX_W'(i)) begin
        a_limb = a_reg[8*i +: 8];
        b_limb = b_reg[8*i +: 8];
      end
    end
    limb_sum    = {1'b0, a_limb} + {1'b0, b_limb} + {8'b0, carry_reg};
    result_next = result_reg;
    for (int i = 0; i < WORDS; i++) begin
      if (idx == IDX_W'(i)) result_next[8*i +: 8] = limb_sum[7:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg      <= '0;
      b_reg      <= '0;
      carry_reg  <= 1'b0;
      result_reg <= '0;
      idx        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= carry_in;
            idx       <= '0;
          end
        end
        RUN: begin
          result_reg <= result_next;
          carry_reg  <= limb_sum[8];
          if (idx != LAST_IDX) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Handshake outputs come from the state register only, never from inputs.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign sum       = result_reg;
  assign carry_out = carry_reg;

endmodule

// File: doc/multiword_add_seq.md
# multiword_add_seq

Sequencing controller that performs a `WORDS`×8-bit addition by reusing a single 8-bit add-with-carry datapath once per byte limb, least-significant limb first. A registered carry is chained between limbs. Operands enter and the result leaves through valid/ready handshakes. The block sits between a requester issuing wide additions and the shared 8-bit adder resource, trading latency for area.

## Interface
- `WORDS`, default 4: number of 8-bit limbs. Legal range is ≥1. Operand and result width is 8·`WORDS`.
- `clk` in, 1: single clock. All state changes on the rising edge.
- `rst` in, 1: asynchronous, active-high reset.
- `in_valid` in, 1: request carries a valid operand set.
- `in_ready` out, 1: block can accept a request.
- `a` in, 8·`WORDS`: operand A, limb i = bits [8i+7:8i].
- `b` in, 8·`WORDS`: operand B.
- `carry_in` in, 1: carry into limb 0.
- `out_valid` out, 1: result available.
- `out_ready` in, 1: consumer accepts the result.
- `sum` out, 8·`WORDS`: result, (a + b + carry_in) mod 2^(8·`WORDS`).
- `carry_out` out, 1: carry out of the top limb.
- `busy` out, 1: high in RUN or DONE.

## Operation
- FSM has three states: IDLE, RUN, DONE.
- **IDLE:** `in_ready`=1, `out_valid`=0. When `in_valid`=1 at an edge:
  - capture `a`, `b` and `carry_in` into internal registers;
  - set limb index `idx`=0;
  - go to RUN.
- **RUN:** `in_ready`=0. On each edge:
  - compute the 9-bit value {c,s} = A[idx] + B[idx] + carry_reg, with operands zero-extended to 9 bits;
  - write `s` to limb `idx` of the result register;
  - set carry_reg←c and `idx`←`idx`+1.
  - On the edge processing `idx`=`WORDS`-1, go to DONE. `idx` never exceeds `WORDS`-1.
- **DONE:**
  - `out_valid`=1.
  - `sum` = result register; `carry_out` = carry_reg.
  - Both outputs are held stable while `out_ready`=0.
  - On an edge with `out_ready`=1, go to IDLE. `in_ready` stays 0 in DONE, so there is no accept in the same cycle.
- Changes on `a`, `b` or `carry_in` after the accept edge have no effect on the operation in progress.
- `in_valid` in RUN/DONE is ignored; the request is not consumed. `out_ready` outside DONE is ignored.
- `sum` and `carry_out` are defined for checking only while `out_valid`=1. Outside DONE they show the internal registers, which can hold partial values during RUN.
- Reset (asynchronous, any state):
  - state goes to IDLE; `idx`, the carry, operand and result registers all clear to 0;
  - the in-flight operation is discarded and no `out_valid` pulse follows;
  - outputs during and after reset: `in_ready`=1, `out_valid`=0, `busy`=0, `sum`=0, `carry_out`=0.

## Timing
- Accept edge T0 is an edge in IDLE with `in_valid`=1.
- Limbs 0..`WORDS`-1 are processed on edges T1..T`WORDS`.
- `out_valid` is high from just after edge T`WORDS`.
- Latency from accept edge to `out_valid` is `WORDS` cycles.
- Minimum issue interval, with `out_ready` tied 1 and `in_valid` held 1, is `WORDS`+2 cycles. For `WORDS`=4, accepts occur at T0, T6, T12, …
- Each cycle of `out_ready`=0 in DONE extends the interval by 1 cycle.
- `in_ready`, `out_valid` and `busy` are decoded from registered state only, with no combinational path from inputs. This keeps the handshake free of combinational loops.
- After `rst` deasserts, the first accept can occur on the first rising edge.

## Test plan
- `WORDS`=4, `a`=0xFFFFFFFF, `b`=0x00000001, `carry_in`=0 → `out_valid` 4 cycles after accept, `sum`=0x00000000, `carry_out`=1.
- `WORDS`=4, `a`=0x12345678, `b`=0x11111111, `carry_in`=1 → `sum`=0x2345678A, `carry_out`=0. After accept, drive `a`/`b` to 0 during RUN → result unchanged.
- Backpressure: the previous case with `out_ready`=0 for 3 cycles in DONE → `out_valid` stays 1, `sum`/`carry_out` are stable, `in_ready`=0 throughout. Release → `out_valid` falls on the next edge and `in_ready`=1.
- Reset mid-RUN: assert `rst` 2 cycles after accept → immediately `in_ready`=1, `out_valid`=0, `sum`=0. No `out_valid` appears in the following 10 cycles with `in_valid`=0.
- Back-to-back: `in_valid` held 1, `out_ready`=1, three random operand sets (`WORDS`=4) → accepts every 6 cycles, each result matches the reference model (a+b+cin).
- `WORDS`=1: `a`=0xFF, `b`=0xFF, `carry_in`=1 → `out_valid` 1 cycle after accept, `sum`=0xFF, `carry_out`=1.
